// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE sequencing controller.
package pe_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_K      = 11;
  localparam int DEF_MAX_N      = 255;
  localparam int DEF_MULT_LAT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pe_state_t;

  // Bits needed to hold any count from 0 up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Job descriptor, operand handshake and PE control signals of the sequencer.
interface pe_seq_ctrl_if
  import pe_pkg::*;
#(
  parameter int MAX_K = DEF_MAX_K,
  parameter int MAX_N = DEF_MAX_N
) ();

  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [cnt_width(MAX_K)-1:0]  cfg_k;
  logic [cnt_width(MAX_N)-1:0]  cfg_n;
  logic                         abort;
  logic                         in_valid;
  logic                         in_ready;
  logic                         mult_seln;
  logic                         acc_seln;
  logic                         opsum_valid;
  logic                         busy;
  logic                         done;
  logic                         cfg_err;

  modport master (
    output cfg_valid, cfg_k, cfg_n, abort, in_valid,
    input  cfg_ready, in_ready, mult_seln, acc_seln, opsum_valid, busy, done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_k, cfg_n, abort, in_valid,
    output cfg_ready, in_ready, mult_seln, acc_seln, opsum_valid, busy, done, cfg_err
  );

endinterface

// File: rtl/pe_seq_ctrl_delay.sv
// Clearable shift register that lines up per-accept flags with the PE product.
module pe_ctrl_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: steps k taps by n windows and drives the PE multiply and
// accumulate selects, delayed to match the multiplier latency.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_K      = DEF_MAX_K,
  parameter int MAX_N      = DEF_MAX_N,
  parameter int MULT_LAT   = DEF_MULT_LAT
) (
  input  logic         clk,
  input  logic         rstn,
  pe_seq_ctrl_if.slave bus
);

  localparam int KW = cnt_width(MAX_K);
  localparam int NW = cnt_width(MAX_N);
  localparam int LW = cnt_width(MULT_LAT);
  localparam bit PARAMS_OK = (DATA_WIDTH > 0) && (MULT_LAT > 0);

  pe_state_t         state;
  logic [KW-1:0]     k_reg, tap_cnt;
  logic [NW-1:0]     n_reg, win_cnt;
  logic [LW-1:0]     drain_cnt;
  logic              cfg_ready_r, in_ready_r, busy_r, done_r, cfg_err_r;
  logic              cfg_ok, kill, accept, first_tap, last_tap, last_win;
  logic [2:0]        d_out;

  assign cfg_ok    = PARAMS_OK
                     && (bus.cfg_k != '0) && (bus.cfg_k <= KW'(MAX_K))
                     && (bus.cfg_n != '0) && (bus.cfg_n <= NW'(MAX_N));
  assign kill      = bus.abort && (state != ST_IDLE);
  assign accept    = bus.in_valid && in_ready_r && !bus.abort;
  assign first_tap = (tap_cnt == '0);
  assign last_tap  = (tap_cnt == k_reg - KW'(1));
  assign last_win  = (win_cnt == n_reg - NW'(1));

  // Abort outranks every state transition; in IDLE it only blocks the handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      k_reg       <= '0;
      n_reg       <= '0;
      tap_cnt     <= '0;
      win_cnt     <= '0;
      drain_cnt   <= '0;
      cfg_ready_r <= 1'b1;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      if (kill) begin
        state       <= ST_IDLE;
        tap_cnt     <= '0;
        win_cnt     <= '0;
        drain_cnt   <= '0;
        cfg_ready_r <= 1'b1;
        in_ready_r  <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.cfg_valid && !bus.abort) begin
              if (cfg_ok) begin
                k_reg       <= bus.cfg_k;
                n_reg       <= bus.cfg_n;
                tap_cnt     <= '0;
                win_cnt     <= '0;
                state       <= ST_RUN;
                cfg_ready_r <= 1'b0;
                in_ready_r  <= 1'b1;
                busy_r      <= 1'b1;
              end else begin
                cfg_err_r <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (accept) begin
              if (last_tap) begin
                tap_cnt <= '0;
                if (last_win) begin
                  state      <= ST_DRAIN;
                  in_ready_r <= 1'b0;
                  drain_cnt  <= '0;
                end else begin
                  win_cnt <= win_cnt + NW'(1);
                end
              end else begin
                tap_cnt <= tap_cnt + KW'(1);
              end
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == LW'(MULT_LAT - 1)) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + LW'(1);
            end
          end
          ST_DONE: begin
            state       <= ST_IDLE;
            busy_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  pe_ctrl_delay #(
    .DEPTH (MULT_LAT),
    .WIDTH (3)
  ) u_delay (
    .clk  (clk),
    .rstn (rstn),
    .clr  (kill),
    .din  ({accept, first_tap, last_tap}),
    .dout (d_out)
  );

  assign bus.cfg_ready   = cfg_ready_r;
  assign bus.in_ready    = in_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.cfg_err     = cfg_err_r;
  assign bus.mult_seln   = d_out[2];
  assign bus.acc_seln    = d_out[2] & d_out[1];
  assign bus.opsum_valid = d_out[2] & d_out[0];

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed vector bench for pe_seq_ctrl with MULT_LAT=1, MAX_K=11, MAX_N=255.
module tb_pe_seq_ctrl;

  logic clk;
  logic rstn;

  pe_seq_ctrl_if #(.MAX_K(11), .MAX_N(255)) bus ();

  pe_seq_ctrl #(
    .DATA_WIDTH (16),
    .MAX_K      (11),
    .MAX_N      (255),
    .MULT_LAT   (1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output order: cfg_ready,in_ready,mult_seln,acc_seln,opsum_valid,busy,done,cfg_err
  typedef struct {
    logic       rstn;
    logic       cfg_valid;
    logic [3:0] k;
    logic [7:0] n;
    logic       abort;
    logic       in_valid;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add_vec(input logic r, input logic cv, input logic [3:0] k, input logic [7:0] n,
                         input logic ab, input logic iv, input logic [7:0] e);
    vec_t v;
    v.rstn = r; v.cfg_valid = cv; v.k = k; v.n = n; v.abort = ab; v.in_valid = iv; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    rstn          = v.rstn;
    bus.cfg_valid = v.cfg_valid;
    bus.cfg_k     = v.k;
    bus.cfg_n     = v.n;
    bus.abort     = v.abort;
    bus.in_valid  = v.in_valid;
  endtask

  task automatic check_output(input int idx, input logic [7:0] want);
    logic [7:0] got;
    got = {bus.cfg_ready, bus.in_ready, bus.mult_seln, bus.acc_seln,
           bus.opsum_valid, bus.busy, bus.done, bus.cfg_err};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL vec%0d outputs got=%b want=%b (cfg_ready,in_ready,mult,acc,opsum,busy,done,cfg_err)",
               idx, got, want);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  int n_rdy, n_op, n_acc, last_rdy, op_cyc, done_cyc, seen;

  initial begin
    rstn = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_k = '0; bus.cfg_n = '0;
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    // k=3 n=2 continuous
    add_vec(1, 1, 4'd3, 8'd2, 0, 1, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01110100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01100100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01101100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01110100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01100100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00101100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00000110);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    // k=3 n=1 with a 4-cycle stall after tap 1
    add_vec(1, 1, 4'd3, 8'd1, 0, 1, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01110100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b01100100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00101100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00000110);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    // bad descriptors: k=0, k=12, n=0
    add_vec(1, 1, 4'd0,  8'd1, 0, 1, 8'b10000000);
    add_vec(1, 1, 4'd12, 8'd1, 0, 1, 8'b10000001);
    add_vec(1, 1, 4'd3,  8'd0, 0, 1, 8'b10000001);
    add_vec(1, 0, 4'd0,  8'd0, 0, 0, 8'b10000001);
    add_vec(1, 0, 4'd0,  8'd0, 0, 0, 8'b10000000);
    // abort in IDLE drops a good descriptor
    add_vec(1, 1, 4'd2, 8'd1, 1, 0, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    // k=1 n=4 back-to-back windows
    add_vec(1, 1, 4'd1, 8'd4, 0, 1, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01111100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01111100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01111100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00111100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00000110);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    // abort during window 1 of k=2 n=3
    add_vec(1, 1, 4'd2, 8'd3, 0, 1, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01110100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01101100);
    add_vec(1, 0, 4'd0, 8'd0, 1, 1, 8'b01110100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    // abort in DRAIN suppresses done
    add_vec(1, 1, 4'd1, 8'd1, 0, 1, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 1, 0, 8'b00111100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);
    // reset mid-RUN, then k=2 n=1 runs to completion
    add_vec(1, 1, 4'd2, 8'd3, 0, 1, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(0, 0, 4'd0, 8'd0, 0, 1, 8'b01110100);
    add_vec(1, 1, 4'd2, 8'd1, 0, 1, 8'b10000000);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01000100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 1, 8'b01110100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00101100);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b00000110);
    add_vec(1, 0, 4'd0, 8'd0, 0, 0, 8'b10000000);

    for (int i = 0; i < tbl.size(); i++) begin
      check_output(i, tbl[i].exp);
      apply_stimulus(tbl[i]);
      @(posedge clk);
      #1;
    end

    // k at its maximum (11), n=1, continuous input
    bus.cfg_valid = 1'b1; bus.cfg_k = 4'd11; bus.cfg_n = 8'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    n_rdy = 0; n_op = 0; last_rdy = -1; op_cyc = -1; done_cyc = -1; seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      if (bus.in_ready)    begin n_rdy++; last_rdy = c; end
      if (bus.opsum_valid) begin n_op++;  op_cyc = c;   end
      if (bus.done)        begin seen = 1; done_cyc = c; end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check_val("kmax_done_seen", seen, 1);
    check_val("kmax_in_ready_cycles", n_rdy, 11);
    check_val("kmax_opsum_pulses", n_op, 1);
    check_val("kmax_opsum_latency", op_cyc - last_rdy, 1);
    check_val("kmax_done_latency", done_cyc - last_rdy, 2);
    check_val("kmax_idle_cfg_ready", int'(bus.cfg_ready), 1);
    check_val("kmax_idle_busy", int'(bus.busy), 0);

    // n at its maximum (255), k=1
    bus.cfg_valid = 1'b1; bus.cfg_k = 4'd1; bus.cfg_n = 8'd255; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    n_rdy = 0; n_op = 0; n_acc = 0; seen = 0;
    for (int c = 0; c < 400 && seen == 0; c++) begin
      if (bus.in_ready)    n_rdy++;
      if (bus.opsum_valid) n_op++;
      if (bus.acc_seln)    n_acc++;
      if (bus.done)        seen = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check_val("nmax_done_seen", seen, 1);
    check_val("nmax_in_ready_cycles", n_rdy, 255);
    check_val("nmax_opsum_pulses", n_op, 255);
    check_val("nmax_acc_seln_pulses", n_acc, 255);
    check_val("nmax_idle_cfg_ready", int'(bus.cfg_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, PE operand width (passed through for package consistency).
REQ-002 SHALL have parameter MAX_K, default 11, maximum filter taps per window.
REQ-003 SHALL have parameter MAX_N, default 255, maximum output windows per job.
REQ-004 SHALL have parameter MULT_LAT, default 1, PE multiplier latency in cycles.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rstn, input, 1; one clock; reset is synchronous and active-low.
REQ-007 SHALL have port cfg_valid, input, 1, job descriptor present.
REQ-008 SHALL have port cfg_ready, output, 1, descriptor accepted when cfg_valid and cfg_ready are both 1.
REQ-009 SHALL have port cfg_k, input, $clog2(MAX_K+1), taps per window.
REQ-010 SHALL have port cfg_n, input, $clog2(MAX_N+1), windows per job.
REQ-011 SHALL have port abort, input, 1, synchronous job kill.
REQ-012 SHALL have port in_valid, input, 1, ifmap/fltr pair valid at PE inputs.
REQ-013 SHALL have port in_ready, output, 1, the pair is consumed on in_valid and in_ready.
REQ-014 SHALL have ports mult_seln and acc_seln, output, 1 each, driving the PE control interface.
REQ-015 SHALL have port opsum_valid, output, 1, PE opsum holds a finished window this cycle.
REQ-016 SHALL have ports busy and done (1-cycle pulse) and cfg_err (1-cycle pulse), output, 1 each.

Function
REQ-017 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-018 In IDLE, cfg_ready SHALL be 1; on a handshake with 1<=cfg_k<=MAX_K and 1<=cfg_n<=MAX_N, the block SHALL latch k and n, clear tap_cnt and win_cnt, and go to RUN the next cycle.
REQ-019 A descriptor with k or n equal to 0 or above its maximum SHALL be consumed, SHALL pulse cfg_err the next cycle, and SHALL leave the block in IDLE.
REQ-020 in_ready SHALL equal 1 only in RUN; every accepted pair SHALL increment tap_cnt.
REQ-021 When tap_cnt reaches k-1 on an accept, tap_cnt SHALL wrap to 0 and win_cnt SHALL increment.
REQ-022 If in_valid is 0 in RUN, all counters SHALL hold (stall); there is no timeout.
REQ-023 The accept strobe and a first-tap flag (tap_cnt==0) SHALL be delayed through a MULT_LAT-deep shift register to align with the PE product.
REQ-024 mult_seln SHALL be the delayed accept strobe.
REQ-025 acc_seln SHALL be the delayed first-tap flag ANDed with the delayed accept, clearing PE accumulator feedback at each window start.
REQ-026 opsum_valid SHALL pulse exactly 1 cycle, MULT_LAT cycles after the accept of each window's last tap.
REQ-027 The accept of the last tap of window n-1 SHALL move the block to DRAIN; DRAIN SHALL last MULT_LAT cycles (emptying the shift register) and then go to DONE.
REQ-028 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-029 k=1 SHALL yield acc_seln and opsum_valid on every product, with windows back-to-back and no bubble.
REQ-030 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-031 abort in any non-IDLE state SHALL go to IDLE next cycle, clear the counters and shift register, and suppress done and opsum_valid.
REQ-032 abort in IDLE SHALL be ignored and SHALL take precedence over a simultaneous cfg handshake, which is dropped.

Reset
REQ-033 With rstn=0 at a clk edge, the block SHALL enter IDLE and all outputs SHALL be 0 except cfg_ready=1 the following cycle; counters and shift register SHALL be 0.
REQ-034 Reset mid-job SHALL discard the job with no done and no opsum_valid.

Structure
REQ-035 The state enum, the MAX_K/MAX_N/MULT_LAT defaults and the counter width functions SHALL reside in shared package pe_pkg.
REQ-036 The MULT_LAT alignment shift register SHALL be sub-module pe_ctrl_delay (parameter DEPTH); all other logic SHALL be flat.

Verification
REQ-037 With MULT_LAT=1, cfg k=3, n=2 and continuous in_valid: in_ready high 6 cycles; acc_seln at product 0 and 3; opsum_valid 1 cycle after accepts 2 and 5; done 2 cycles after accept 5.
REQ-038 k=3, n=1 with in_valid deasserted 4 cycles after tap 1: counters hold; opsum_valid only 1 cycle after the tap 2 accept.
REQ-039 cfg k=0, then k=12 (MAX_K=11): cfg_err pulses each time, busy stays 0, in_ready never 1.
REQ-040 k=1, n=4: opsum_valid and acc_seln high 4 consecutive cycles.
REQ-041 abort asserted during window 1 of n=3: next cycle IDLE, cfg_ready=1, no done, no further opsum_valid.
REQ-042 rstn low 1 cycle mid-RUN: next cycle all outputs 0 except cfg_ready=1; a new job k=2, n=1 completes normally.
